ts_pkt_gen: RTL and testbench

Parametrised MPEG transport-stream packet generator driving a parallel TS interface (clk, data, sync, valid) of 8, 16 or 32 bits. It produces well-formed packets with sync byte 0x47, a configurable PID, a 4-bit continuity counter and a deterministic payload. It supports programmable inter-packet gaps, mid-packet stalls and null-packet insertion. It sits at the source end of TS test chains and feeds downstream TS sinks, width converters and checkers.

---
 rtl/ts_pkg.sv | 37 +++
 rtl/ts_byte_map.sv | 37 +++
 rtl/ts_pkt_gen.sv | 149 ++++++++++++++
 tb/tb_ts_pkt_gen.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ts_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ts_pkg : shared constants, encodings and byte-map helper for the TS generator
// Rev 1.0
// ----------------------------------------------------------------------------
package ts_pkg;

  localparam logic [7:0]  TS_SYNC_BYTE       = 8'h47;
  localparam logic [12:0] TS_NULL_PID        = 13'h1FFF;
  localparam int          TS_PKT_LEN_DEFAULT = 188;
  localparam int          TS_HDR_LEN         = 4;

  localparam logic [1:0] AFC_RESERVED      = 2'b00;
  localparam logic [1:0] AFC_PAYLOAD_ONLY  = 2'b01;
  localparam logic [1:0] AFC_ADAPT_ONLY    = 2'b10;
  localparam logic [1:0] AFC_ADAPT_PAYLOAD = 2'b11;

  localparam logic [7:0] TS_NULL_FILL = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } ts_state_e;

  // Header byte 1: TEI=0, PUSI=1, priority=0, then the PID high bits.
  function automatic logic [7:0] ts_hdr_b1(input logic [12:0] pid);
    return {1'b0, 1'b1, 1'b0, pid[12:8]};
  endfunction

  // Header byte 3: scrambling=00, adaptation control, continuity counter.
  function automatic logic [7:0] ts_hdr_b3(input logic [3:0] cc);
    return {2'b00, AFC_PAYLOAD_ONLY, cc};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ts_byte_map.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ts_byte_map : combinational map from packet byte index to TS byte value
// Rev 1.0
// ----------------------------------------------------------------------------
module ts_byte_map
  import ts_pkg::*;
(
  input  logic [15:0] byte_idx_i,
  input  logic [12:0] pid_i,
  input  logic [3:0]  cc_i,
  input  logic        null_i,
  output logic [7:0]  byte_o
);

  logic [12:0] eff_pid;
  logic [3:0]  eff_cc;
  logic [7:0]  pay_byte;

  // Null packets force the reserved PID and a zero continuity field.
  assign eff_pid  = null_i ? TS_NULL_PID : pid_i;
  assign eff_cc   = null_i ? 4'h0 : cc_i;
  assign pay_byte = byte_idx_i[7:0] - 8'(TS_HDR_LEN);

  always_comb begin
    byte_o = 8'h00;
    case (byte_idx_i)
      16'd0:   byte_o = TS_SYNC_BYTE;
      16'd1:   byte_o = ts_hdr_b1(eff_pid);
      16'd2:   byte_o = eff_pid[7:0];
      16'd3:   byte_o = ts_hdr_b3(eff_cc);
      default: byte_o = null_i ? TS_NULL_FILL : pay_byte;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ts_pkt_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ts_pkt_gen : MPEG-TS packet generator on a parallel TS interface
// Rev 1.0
// ----------------------------------------------------------------------------
module ts_pkt_gen
  import ts_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int PACKET_LEN = TS_PKT_LEN_DEFAULT,
  parameter int GAP_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [12:0]       pid,
  input  logic              null_pkt,
  output logic              ts_par_clk,
  output logic [DATA_W-1:0] ts_par_data,
  output logic              ts_par_sync,
  output logic              ts_par_valid,
  output logic [31:0]       pkt_cnt
);

  localparam int BPW = (DATA_W >= 8) ? DATA_W / 8 : 1;
  localparam int WPP = PACKET_LEN / BPW;
  localparam int WCW = (WPP > 1) ? $clog2(WPP) : 1;
  localparam int GCW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [WCW-1:0] LAST_WORD = WCW'(WPP - 1);
  localparam logic [GCW-1:0] LAST_GAP  = GCW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  if (!(DATA_W == 8 || DATA_W == 16 || DATA_W == 32)) begin : g_bad_data_w
    $error("ts_pkt_gen: DATA_W must be 8, 16 or 32");
  end
  if ((PACKET_LEN % BPW) != 0) begin : g_bad_pkt_len
    $error("ts_pkt_gen: PACKET_LEN must be a multiple of DATA_W/8");
  end
  if (PACKET_LEN < 5) begin : g_short_pkt
    $error("ts_pkt_gen: PACKET_LEN must be at least 5");
  end

  ts_state_e         state_q;
  logic [WCW-1:0]    word_q;
  logic [GCW-1:0]    gap_q;
  logic [3:0]        cc_q;
  logic [12:0]       pid_q;
  logic              null_q;
  logic [DATA_W-1:0] data_q;
  logic              sync_q;
  logic              valid_q;
  logic [31:0]       pkt_cnt_q;

  logic              first_word;
  logic              last_word;
  logic [12:0]       cur_pid;
  logic              cur_null;
  logic [DATA_W-1:0] word_data;

  assign first_word = (word_q == '0);
  assign last_word  = (word_q == LAST_WORD);

  // On the first word the live inputs are what gets captured, so use them directly.
  assign cur_pid  = first_word ? pid : pid_q;
  assign cur_null = first_word ? null_pkt : null_q;

  for (genvar j = 0; j < BPW; j++) begin : g_byte
    logic [15:0] byte_idx;
    assign byte_idx = 16'(word_q) * 16'(BPW) + 16'(j);

    ts_byte_map u_map (
      .byte_idx_i (byte_idx),
      .pid_i      (cur_pid),
      .cc_i       (cc_q),
      .null_i     (cur_null),
      .byte_o     (word_data[DATA_W-1-8*j -: 8])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      word_q    <= '0;
      gap_q     <= '0;
      cc_q      <= 4'h0;
      pid_q     <= 13'h0;
      null_q    <= 1'b0;
      data_q    <= '0;
      sync_q    <= 1'b0;
      valid_q   <= 1'b0;
      pkt_cnt_q <= 32'h0;
    end else begin
      sync_q  <= 1'b0;
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (en) begin
            state_q <= ST_SEND;
            word_q  <= '0;
          end
        end

        ST_SEND: begin
          if (en) begin
            data_q  <= word_data;
            valid_q <= 1'b1;
            sync_q  <= first_word;
            if (first_word) begin
              pid_q  <= pid;
              null_q <= null_pkt;
            end
            if (last_word) begin
              word_q    <= '0;
              pkt_cnt_q <= pkt_cnt_q + 32'd1;
              if (!cur_null) begin
                cc_q <= cc_q + 4'd1;
              end
              // Without a gap the FSM stays in SEND and the next packet follows at once.
              if (GAP_CYCLES > 0) begin
                state_q <= ST_GAP;
                gap_q   <= '0;
              end
            end else begin
              word_q <= word_q + 1'b1;
            end
          end
        end

        ST_GAP: begin
          if (gap_q == LAST_GAP) begin
            state_q <= en ? ST_SEND : ST_IDLE;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ts_par_clk   = clk;
  assign ts_par_data  = data_q;
  assign ts_par_sync  = sync_q;
  assign ts_par_valid = valid_q;
  assign pkt_cnt      = pkt_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ts_pkt_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ts_pkt_gen : self-checking bench for ts_pkt_gen (8-, 32- and 16-bit/gap builds)
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_ts_pkt_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // 8-bit, no gap
  logic        rst_a, en_a, null_a;
  logic [12:0] pid_a;
  logic        pclk_a, sync_a, valid_a;
  logic [7:0]  data_a;
  logic [31:0] cnt_a;

  // 32-bit, no gap
  logic        rst_b, en_b, null_b;
  logic [12:0] pid_b;
  logic        pclk_b, sync_b, valid_b;
  logic [31:0] data_b;
  logic [31:0] cnt_b;

  // 16-bit, 3-cycle gap
  logic        rst_c, en_c, null_c;
  logic [12:0] pid_c;
  logic        pclk_c, sync_c, valid_c;
  logic [15:0] data_c;
  logic [31:0] cnt_c;

  ts_pkt_gen #(.DATA_W(8), .PACKET_LEN(188), .GAP_CYCLES(0)) u_a (
    .clk(clk), .rst(rst_a), .en(en_a), .pid(pid_a), .null_pkt(null_a),
    .ts_par_clk(pclk_a), .ts_par_data(data_a), .ts_par_sync(sync_a),
    .ts_par_valid(valid_a), .pkt_cnt(cnt_a));

  ts_pkt_gen #(.DATA_W(32), .PACKET_LEN(188), .GAP_CYCLES(0)) u_b (
    .clk(clk), .rst(rst_b), .en(en_b), .pid(pid_b), .null_pkt(null_b),
    .ts_par_clk(pclk_b), .ts_par_data(data_b), .ts_par_sync(sync_b),
    .ts_par_valid(valid_b), .pkt_cnt(cnt_b));

  ts_pkt_gen #(.DATA_W(16), .PACKET_LEN(188), .GAP_CYCLES(3)) u_c (
    .clk(clk), .rst(rst_c), .en(en_c), .pid(pid_c), .null_pkt(null_c),
    .ts_par_clk(pclk_c), .ts_par_data(data_c), .ts_par_sync(sync_c),
    .ts_par_valid(valid_c), .pkt_cnt(cnt_c));

  // Expected byte k of a packet, straight from the packet layout rules.
  function automatic logic [7:0] ref_byte(input int k, input logic [12:0] p,
                                          input logic [3:0] cc, input logic n);
    logic [12:0] pp;
    pp = n ? 13'h1FFF : p;
    if (k == 0) return 8'h47;
    if (k == 1) return {3'b010, pp[12:8]};
    if (k == 2) return pp[7:0];
    if (k == 3) return n ? 8'h10 : {4'h1, cc};
    return n ? 8'hFF : 8'((k - 4) % 256);
  endfunction

  // Stream-level model of the 8-bit instance.
  bit          started_m;
  int          pos_m;
  logic [3:0]  cc_m;
  logic [31:0] cnt_m;
  logic [12:0] ppid_m;
  logic        pnull_m;
  logic [7:0]  exp_d_a;
  logic        exp_v_a, exp_s_a;
  logic [7:0]  seen_a[$];
  bit          seen_s_a[$];

  // Apply one cycle of inputs to the 8-bit instance and compare its outputs.
  task automatic cyc_a(input logic r, input logic e, input logic [12:0] p,
                       input logic n, input string tag);
    rst_a = r; en_a = e; pid_a = p; null_a = n;
    if (r) begin
      started_m = 0; pos_m = 0; cc_m = 4'h0; cnt_m = 32'h0;
      exp_d_a = 8'h00; exp_v_a = 1'b0; exp_s_a = 1'b0;
    end else if (started_m && e) begin
      if (pos_m == 0) begin
        ppid_m = p; pnull_m = n;
      end
      exp_d_a = ref_byte(pos_m, ppid_m, cc_m, pnull_m);
      exp_v_a = 1'b1;
      exp_s_a = (pos_m == 0);
      pos_m++;
      if (pos_m == 188) begin
        pos_m = 0;
        cnt_m = cnt_m + 32'd1;
        if (!pnull_m) cc_m = cc_m + 4'd1;
      end
    end else begin
      exp_v_a = 1'b0; exp_s_a = 1'b0;
      if (e) started_m = 1;
    end
    @(negedge clk);
    if (valid_a === 1'b1) begin
      seen_a.push_back(data_a);
      seen_s_a.push_back(sync_a);
    end
    n_checks++;
    if ({valid_a, sync_a, data_a, cnt_a} !== {exp_v_a, exp_s_a, exp_d_a, cnt_m}) begin
      n_errors++;
      $display("FAIL %s: got v=%b s=%b d=%h cnt=%0d, want v=%b s=%b d=%h cnt=%0d",
               tag, valid_a, sync_a, data_a, cnt_a, exp_v_a, exp_s_a, exp_d_a, cnt_m);
    end
  endtask

  task automatic test_reset();
    cyc_a(1'b1, 1'b0, 13'h0, 1'b0, "reset");
    cyc_a(1'b1, 1'b1, 13'h0, 1'b0, "reset_en_high");
    n_checks++;
    if ({data_a, sync_a, valid_a, cnt_a, pclk_a} !== {8'h00, 1'b0, 1'b0, 32'h0, clk}) begin
      n_errors++;
      $display("FAIL reset_values: got d=%h s=%b v=%b cnt=%0d clk=%b, want zeros and clk=%b",
               data_a, sync_a, valid_a, cnt_a, pclk_a, clk);
    end
  endtask

  task automatic test_basic();
    int          idx[9]  = '{0, 1, 2, 3, 4, 5, 187, 188, 191};
    logic [7:0]  expv[9] = '{8'h47, 8'h41, 8'h00, 8'h10, 8'h00, 8'h01, 8'hB7, 8'h47, 8'h11};
    int          nsync;
    seen_a.delete(); seen_s_a.delete();
    for (int i = 0; i < 377; i++) cyc_a(1'b0, 1'b1, 13'h100, 1'b0, "basic");
    n_checks++;
    if (seen_a.size() != 376) begin
      n_errors++;
      $display("FAIL basic_len: got %0d words, want 376", seen_a.size());
    end
    for (int i = 0; i < 9; i++) begin
      n_checks++;
      if (seen_a[idx[i]] !== expv[i]) begin
        n_errors++;
        $display("FAIL basic_byte%0d: got %h, want %h", idx[i], seen_a[idx[i]], expv[i]);
      end
    end
    nsync = 0;
    foreach (seen_s_a[i]) if (seen_s_a[i]) nsync++;
    n_checks++;
    if (nsync != 2 || !seen_s_a[0] || !seen_s_a[188]) begin
      n_errors++;
      $display("FAIL basic_sync: got %0d syncs, want 2 at words 0 and 188", nsync);
    end
    n_checks++;
    if (cnt_a !== 32'd2) begin
      n_errors++;
      $display("FAIL basic_pkt_cnt: got %0d, want 2", cnt_a);
    end
  endtask

  task automatic test_stall();
    int lows;
    seen_a.delete(); seen_s_a.delete();
    for (int i = 0; i < 20; i++) cyc_a(1'b0, 1'b1, 13'h100, 1'b0, "stall_pre");
    lows = 0;
    for (int i = 0; i < 5; i++) begin
      cyc_a(1'b0, 1'b0, 13'h100, 1'b0, "stall_hold");
      if (valid_a === 1'b0 && data_a === 8'h0F) lows++;
    end
    for (int i = 0; i < 168; i++) cyc_a(1'b0, 1'b1, 13'h100, 1'b0, "stall_post");
    n_checks++;
    if (lows != 5) begin
      n_errors++;
      $display("FAIL stall_hold: got %0d idle cycles holding 0f, want 5", lows);
    end
    n_checks++;
    if (seen_a.size() != 188 || seen_a[3] !== 8'h12 || seen_a[19] !== 8'h0F || seen_a[20] !== 8'h10) begin
      n_errors++;
      $display("FAIL stall_words: got n=%0d b3=%h w19=%h w20=%h, want 188 12 0f 10",
               seen_a.size(), seen_a[3], seen_a[19], seen_a[20]);
    end
  endtask

  task automatic test_null();
    cyc_a(1'b1, 1'b0, 13'h0, 1'b0, "null_rst");
    seen_a.delete(); seen_s_a.delete();
    for (int i = 0; i < 565; i++)
      cyc_a(1'b0, 1'b1, 13'h100, (i >= 189 && i < 377), "null");
    n_checks++;
    if ({seen_a[188], seen_a[189], seen_a[190], seen_a[191]} !== 32'h475FFF10) begin
      n_errors++;
      $display("FAIL null_header: got %h%h%h%h, want 475fff10",
               seen_a[188], seen_a[189], seen_a[190], seen_a[191]);
    end
    n_checks++;
    if (seen_a[250] !== 8'hFF || seen_a[375] !== 8'hFF) begin
      n_errors++;
      $display("FAIL null_payload: got %h %h, want ff ff", seen_a[250], seen_a[375]);
    end
    n_checks++;
    if (seen_a[3] !== 8'h10 || seen_a[379] !== 8'h11) begin
      n_errors++;
      $display("FAIL null_cc: got pkt1 %h pkt3 %h, want 10 11", seen_a[3], seen_a[379]);
    end
    n_checks++;
    if (cnt_a !== 32'd3) begin
      n_errors++;
      $display("FAIL null_pkt_cnt: got %0d, want 3", cnt_a);
    end
  endtask

  task automatic test_reset_mid();
    cyc_a(1'b1, 1'b0, 13'h0, 1'b0, "mid_rst0");
    for (int i = 0; i < 239; i++) cyc_a(1'b0, 1'b1, 13'h100, 1'b0, "mid_pre");
    cyc_a(1'b1, 1'b1, 13'h100, 1'b0, "mid_rst");
    n_checks++;
    if ({valid_a, sync_a, data_a, cnt_a} !== 42'h0) begin
      n_errors++;
      $display("FAIL mid_reset: got v=%b s=%b d=%h cnt=%0d, want all 0",
               valid_a, sync_a, data_a, cnt_a);
    end
    seen_a.delete(); seen_s_a.delete();
    for (int i = 0; i < 189; i++) cyc_a(1'b0, 1'b1, 13'h100, 1'b0, "mid_post");
    n_checks++;
    if (seen_a[3] !== 8'h10 || cnt_a !== 32'd1) begin
      n_errors++;
      $display("FAIL mid_restart: got b3=%h cnt=%0d, want 10 and 1", seen_a[3], cnt_a);
    end
  endtask

  task automatic test_random();
    cyc_a(1'b1, 1'b0, 13'h0, 1'b0, "rand_rst");
    for (int i = 0; i < 1500; i++)
      cyc_a(($urandom_range(0, 499) == 0), ($urandom_range(0, 3) != 0),
            13'($urandom), ($urandom_range(0, 3) == 0), "random");
  endtask

  task automatic test_wide();
    logic [31:0] w[$];
    bit          s[$];
    logic [31:0] e;
    int          nsync;
    rst_b = 1'b1; en_b = 1'b0; pid_b = 13'h0A5; null_b = 1'b0;
    @(negedge clk);
    rst_b = 1'b0; en_b = 1'b1;
    for (int i = 0; i < 95; i++) begin
      @(negedge clk);
      if (valid_b === 1'b1) begin
        w.push_back(data_b);
        s.push_back(sync_b);
      end
    end
    n_checks++;
    if (w.size() != 94) begin
      n_errors++;
      $display("FAIL wide_len: got %0d words, want 94", w.size());
    end
    n_checks++;
    if (w[0] !== 32'h4740A510 || w[1] !== 32'h00010203 || w[46] !== 32'hB4B5B6B7 || w[47] !== 32'h4740A511) begin
      n_errors++;
      $display("FAIL wide_words: got %h %h %h %h, want 4740a510 00010203 b4b5b6b7 4740a511",
               w[0], w[1], w[46], w[47]);
    end
    nsync = 0;
    foreach (s[i]) if (s[i]) nsync++;
    n_checks++;
    if (nsync != 2 || !s[0] || !s[47] || cnt_b !== 32'd2) begin
      n_errors++;
      $display("FAIL wide_sync_cnt: got %0d syncs cnt=%0d, want 2 syncs at 0/47 cnt=2", nsync, cnt_b);
    end
    foreach (w[j]) begin
      for (int m = 0; m < 4; m++)
        e[31-8*m -: 8] = ref_byte((j % 47) * 4 + m, 13'h0A5, 4'(j / 47), 1'b0);
      n_checks++;
      if (w[j] !== e) begin
        n_errors++;
        $display("FAIL wide_word%0d: got %h, want %h", j, w[j], e);
      end
    end
    en_b = 1'b0;
  endtask

  task automatic test_gap();
    logic [12:0] p;
    logic        exp_v;
    int          k, wi, nvalid;
    logic [15:0] e;
    p = 13'($urandom);
    rst_c = 1'b1; en_c = 1'b0; pid_c = p; null_c = 1'b0;
    @(negedge clk);
    rst_c = 1'b0;
    nvalid = 0;
    for (int t = 0; t <= 392; t++) begin
      en_c = !(t >= 289 && t <= 295);
      @(negedge clk);
      exp_v = 1'b0; k = 0; wi = 0;
      if (t >= 1 && t <= 288 && ((t - 1) % 97) < 94) begin
        exp_v = 1'b1; k = (t - 1) / 97; wi = (t - 1) % 97;
      end else if (t >= 297 && t <= 390) begin
        exp_v = 1'b1; k = 3; wi = t - 297;
      end
      e = {ref_byte(2 * wi, p, 4'(k), 1'b0), ref_byte(2 * wi + 1, p, 4'(k), 1'b0)};
      if (valid_c === 1'b1) nvalid++;
      n_checks++;
      if (valid_c !== exp_v || sync_c !== (exp_v && wi == 0) || (exp_v && data_c !== e)) begin
        n_errors++;
        $display("FAIL gap_t%0d: got v=%b s=%b d=%h, want v=%b s=%b d=%h",
                 t, valid_c, sync_c, data_c, exp_v, (exp_v && wi == 0), e);
      end
      if (t == 1 || t == 98) begin
        n_checks++;
        if (data_c !== {8'h47, 3'b010, p[12:8]}) begin
          n_errors++;
          $display("FAIL gap_first_word_t%0d: got %h, want %h", t, data_c, {8'h47, 3'b010, p[12:8]});
        end
      end
    end
    n_checks++;
    if (nvalid != 376 || cnt_c !== 32'd4 || pclk_c !== clk) begin
      n_errors++;
      $display("FAIL gap_totals: got %0d valid cnt=%0d, want 376 and 4", nvalid, cnt_c);
    end
  endtask

  initial begin
    rst_a = 1'b1; en_a = 1'b0; pid_a = 13'h0; null_a = 1'b0;
    rst_b = 1'b1; en_b = 1'b0; pid_b = 13'h0; null_b = 1'b0;
    rst_c = 1'b1; en_c = 1'b0; pid_c = 13'h0; null_c = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_null();
    test_reset_mid();
    test_random();
    test_wide();
    test_gap();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
